// File: rtl/bcd_press_counter_mux.sv
// Debounced press counter with BCD up/down count, modulo wrap, auto-repeat
// and a tick-paced multiplexed 8-segment display driver.
module bcd_press_counter_mux #(
    parameter int CLK_DIV        = 44801,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_TICKS   = 0,
    parameter int DIGITS         = 2,
    parameter int MAX_COUNT      = 99,
    parameter int BLANK_LZ       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn,
    input  logic                  clr,
    input  logic                  up,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     seg_on,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = 4 * DIGITS;

    function automatic logic [31:0] f_to_bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] f_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hFC;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hDA;
            4'd3:    s = 8'hF2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hB6;
            4'd6:    s = 8'hBE;
            4'd7:    s = 8'hE0;
            4'd8:    s = 8'hFE;
            4'd9:    s = 8'hF6;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    localparam logic [31:0] MAX_BCD32 = f_to_bcd(MAX_COUNT);
    localparam logic [CW-1:0] MAX_BCD = MAX_BCD32[CW-1:0];

    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [DW-1:0] r_div;
    logic [BW-1:0] r_db;
    logic [RW-1:0] r_rep;
    logic [CW-1:0] r_cnt;
    logic          r_wrap;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_seg;
    logic [DIGITS-1:0] r_seg_on;

    logic          w_btn_s;
    logic          w_clr_s;
    logic          w_up_s;
    logic          w_tick;
    logic          w_event;
    logic [CW-1:0] w_inc;
    logic [CW-1:0] w_dec;
    logic          w_carry;
    logic          w_borrow;
    logic [IW-1:0] w_idx_nxt;
    logic [3:0]    w_digit;
    logic [DIGITS-1:0] w_lz;
    logic          w_zero_run;
    logic          w_blank;

    // Two-flop synchronizers for {up, clr, btn}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {up, clr, btn};
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = r_sync2[0];
    assign w_clr_s = r_sync2[1];
    assign w_up_s  = r_sync2[2];

    assign w_tick = (r_div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db  <= '0;
            r_rep <= '0;
        end else if (w_tick) begin
            if (!w_btn_s) begin
                r_db  <= '0;
                r_rep <= '0;
            end else if (int'(r_db) < DEBOUNCE_TICKS) begin
                r_db <= r_db + BW'(1);
            end else if (REPEAT_TICKS != 0) begin
                if (int'(r_rep) + 1 >= REPEAT_TICKS) begin
                    r_rep <= '0;
                end else begin
                    r_rep <= r_rep + RW'(1);
                end
            end
        end
    end

    always_comb begin
        w_event = 1'b0;
        if (w_tick && w_btn_s) begin
            if (int'(r_db) < DEBOUNCE_TICKS) begin
                w_event = (int'(r_db) + 1 == DEBOUNCE_TICKS);
            end else if (REPEAT_TICKS != 0) begin
                w_event = (int'(r_rep) + 1 >= REPEAT_TICKS);
            end
        end
    end

    // Ripple BCD increment/decrement of the whole count
    always_comb begin
        w_inc    = '0;
        w_dec    = '0;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!w_carry) begin
                w_inc[4*i +: 4] = r_cnt[4*i +: 4];
            end else if (r_cnt[4*i +: 4] >= 4'd9) begin
                w_inc[4*i +: 4] = 4'd0;
            end else begin
                w_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                w_carry         = 1'b0;
            end
            if (!w_borrow) begin
                w_dec[4*i +: 4] = r_cnt[4*i +: 4];
            end else if (r_cnt[4*i +: 4] == 4'd0) begin
                w_dec[4*i +: 4] = 4'd9;
            end else begin
                w_dec[4*i +: 4] = r_cnt[4*i +: 4] - 4'd1;
                w_borrow        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_clr_s) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_event && w_up_s) begin
            if (r_cnt == MAX_BCD) begin
                r_cnt  <= '0;
                r_wrap <= 1'b1;
            end else begin
                r_cnt  <= w_inc;
                r_wrap <= 1'b0;
            end
        end else if (w_event) begin
            if (r_cnt == '0) begin
                r_cnt  <= MAX_BCD;
                r_wrap <= 1'b1;
            end else begin
                r_cnt  <= w_dec;
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign w_idx_nxt = (int'(r_idx) >= DIGITS - 1) ? '0 : r_idx + IW'(1);

    // w_lz[i]: digit i and every digit above it are zero
    always_comb begin
        w_lz       = '0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_cnt[4*i +: 4] == 4'd0);
            w_lz[i]    = w_zero_run;
        end
    end

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == IW'(i)) begin
                w_digit = r_cnt[4*i +: 4];
                w_blank = (BLANK_LZ != 0) && (i > 0) && w_lz[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx    <= '0;
            r_seg    <= 8'h00;
            r_seg_on <= '1;
        end else if (w_tick) begin
            r_idx    <= w_idx_nxt;
            r_seg    <= w_blank ? 8'h00 : f_decode(w_digit);
            r_seg_on <= ~(DIGITS'(1) << w_idx_nxt);
        end
    end

    assign seg       = r_seg;
    assign seg_on    = r_seg_on;
    assign count_bcd = r_cnt;
    assign wrap      = r_wrap;

endmodule
